// File: rtl/vmu_agen_sched.sv
// Load/store burst scheduler for the shared VMU address generator: round-robin
// grant, beat-by-beat issue, and a tag pipe aligned to the addr_gen latency.
module vmu_agen_sched #(
  parameter int unsigned SCALAR_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH         = 8,
  parameter int unsigned COMMON_AGEN_DELAY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_ld_vld,
  output logic                    o_ld_rdy,
  input  logic [SCALAR_WIDTH-1:0] i_ld_base,
  input  logic [CNT_WIDTH-1:0]    i_ld_len,
  input  logic                    i_st_vld,
  output logic                    o_st_rdy,
  input  logic [SCALAR_WIDTH-1:0] i_st_base,
  input  logic [CNT_WIDTH-1:0]    i_st_len,
  input  logic                    i_issue_en,
  output logic [CNT_WIDTH-1:0]    o_agen_cnt,
  output logic [SCALAR_WIDTH-1:0] o_agen_scalar,
  output logic                    o_addr_vld,
  output logic                    o_addr_is_st,
  output logic                    o_addr_last,
  output logic                    o_done,
  output logic                    o_busy
);

  localparam int unsigned LAST_STAGE = COMMON_AGEN_DELAY - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic vld;
    logic is_st;
    logic last;
    logic done;
  } tag_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    rr_st_pri_q;
  logic [SCALAR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]    len_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    is_st_q;
  logic [CNT_WIDTH-1:0]    agen_cnt_q;
  logic [SCALAR_WIDTH-1:0] agen_scalar_q;

  logic                    ld_gnt;
  logic                    st_gnt;
  logic                    gnt;
  logic                    issue;
  logic                    last_beat;
  logic [CNT_WIDTH-1:0]    gnt_len;
  logic [SCALAR_WIDTH-1:0] gnt_base;
  logic                    gnt_zero;

  tag_t                    tag_in;
  tag_t                    pipe_q [COMMON_AGEN_DELAY];
  logic                    pipe_busy;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, issue decision and next state
  always_comb begin
    state_d   = state_q;
    ld_gnt    = 1'b0;
    st_gnt    = 1'b0;
    issue     = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        // rr_st_pri_q set means the last grant went to load
        if (i_ld_vld && (!i_st_vld || !rr_st_pri_q)) begin
          ld_gnt = 1'b1;
        end else if (i_st_vld) begin
          st_gnt = 1'b1;
        end
        if ((ld_gnt && (i_ld_len != '0)) || (st_gnt && (i_st_len != '0))) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (i_issue_en) begin
          issue     = 1'b1;
          last_beat = (cnt_q == (len_q - CNT_WIDTH'(1)));
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt      = ld_gnt | st_gnt;
  assign gnt_len  = st_gnt ? i_st_len : i_ld_len;
  assign gnt_base = st_gnt ? i_st_base : i_ld_base;
  assign gnt_zero = gnt && (gnt_len == '0);

  // Tag for the pipe: real beat, zero-length completion marker, or bubble
  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.vld   = 1'b1;
      tag_in.is_st = is_st_q;
      tag_in.last  = last_beat;
      tag_in.done  = last_beat;
    end else if (gnt_zero) begin
      tag_in.is_st = st_gnt;
      tag_in.done  = 1'b1;
    end
  end

  // Burst context, RR pointer and addr_gen drive registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_st_pri_q   <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      is_st_q       <= 1'b0;
      agen_cnt_q    <= '0;
      agen_scalar_q <= '0;
    end else begin
      if (gnt) begin
        rr_st_pri_q <= ld_gnt;
        base_q      <= gnt_base;
        len_q       <= gnt_len;
        is_st_q     <= st_gnt;
        cnt_q       <= '0;
      end
      if (issue) begin
        agen_cnt_q    <= cnt_q;
        agen_scalar_q <= base_q;
        cnt_q         <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Tag delay line matching addr_gen latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < COMMON_AGEN_DELAY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < COMMON_AGEN_DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < COMMON_AGEN_DELAY; i++) begin
      pipe_busy = pipe_busy | pipe_q[i].vld | pipe_q[i].done;
    end
  end

  assign o_ld_rdy      = ld_gnt;
  assign o_st_rdy      = st_gnt;
  assign o_agen_cnt    = agen_cnt_q;
  assign o_agen_scalar = agen_scalar_q;
  assign o_addr_vld    = pipe_q[LAST_STAGE].vld;
  assign o_addr_is_st  = pipe_q[LAST_STAGE].is_st;
  assign o_addr_last   = pipe_q[LAST_STAGE].last;
  assign o_done        = pipe_q[LAST_STAGE].done;
  assign o_busy        = (state_q != IDLE) || pipe_busy;

endmodule

// File: tb/tb_vmu_agen_sched.sv
// Directed bench for vmu_agen_sched: reset, single burst, contention,
// backpressure, zero-length, max-length and mid-burst reset.
module tb_vmu_agen_sched;

  localparam int unsigned SW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned D  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_vld, st_vld, issue_en;
  logic          ld_rdy, st_rdy;
  logic [SW-1:0] ld_base, st_base;
  logic [CW-1:0] ld_len, st_len;
  logic [CW-1:0] agen_cnt;
  logic [SW-1:0] agen_scalar;
  logic          addr_vld, addr_is_st, addr_last, done, busy;

  int checks = 0;
  int errors = 0;

  vmu_agen_sched #(
    .SCALAR_WIDTH(SW),
    .CNT_WIDTH(CW),
    .COMMON_AGEN_DELAY(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_ld_vld(ld_vld),
    .o_ld_rdy(ld_rdy),
    .i_ld_base(ld_base),
    .i_ld_len(ld_len),
    .i_st_vld(st_vld),
    .o_st_rdy(st_rdy),
    .i_st_base(st_base),
    .i_st_len(st_len),
    .i_issue_en(issue_en),
    .o_agen_cnt(agen_cnt),
    .o_agen_scalar(agen_scalar),
    .o_addr_vld(addr_vld),
    .o_addr_is_st(addr_is_st),
    .o_addr_last(addr_last),
    .o_done(done),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_vld = 1'b0; st_vld = 1'b0; issue_en = 1'b0;
    ld_base = '0; st_base = '0; ld_len = '0; st_len = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (agen_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", agen_cnt); end
    checks++; if (agen_scalar !== 16'h0) begin errors++; $display("FAIL reset_scalar got %h exp 0", agen_scalar); end
    checks++; if ({addr_vld, addr_is_st, addr_last, done} !== 4'b0) begin errors++; $display("FAIL reset_tag got %b exp 0000", {addr_vld, addr_is_st, addr_last, done}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({ld_rdy, st_rdy} !== 2'b00) begin errors++; $display("FAIL reset_rdy got %b exp 00", {ld_rdy, st_rdy}); end
  endtask

  task automatic test_single_load();
    logic [0:7]    ev;
    logic [0:7]    el;
    logic [CW-1:0] ec [8];
    ev = 8'b00011110;
    el = 8'b00000010;
    ec = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
    do_reset();
    ld_vld = 1'b1; ld_base = 16'h1000; ld_len = 4'd4; issue_en = 1'b1;
    #1;
    checks++; if ({ld_rdy, st_rdy} !== 2'b10) begin errors++; $display("FAIL single_rdy got %b exp 10", {ld_rdy, st_rdy}); end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) ld_vld = 1'b0;
      #1;
      checks++; if (addr_vld !== ev[k-1]) begin errors++; $display("FAIL single_vld k=%0d got %b exp %b", k, addr_vld, ev[k-1]); end
      checks++; if ({addr_last, done} !== {el[k-1], el[k-1]}) begin errors++; $display("FAIL single_last_done k=%0d got %b exp %b%b", k, {addr_last, done}, el[k-1], el[k-1]); end
      if (k >= 2) begin
        checks++; if (agen_cnt !== ec[k-1]) begin errors++; $display("FAIL single_cnt k=%0d got %0d exp %0d", k, agen_cnt, ec[k-1]); end
      end
      if (k == 2) begin
        checks++; if (agen_scalar !== 16'h1000) begin errors++; $display("FAIL single_scalar got %h exp 1000", agen_scalar); end
      end
      if (k == 4) begin
        checks++; if (addr_is_st !== 1'b0) begin errors++; $display("FAIL single_is_st got %b exp 0", addr_is_st); end
      end
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_on got %b exp 1", busy); end
      end
      if (k == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_off got %b exp 0", busy); end
      end
    end
  endtask

  task automatic test_contention();
    logic [0:6]  eld;
    logic [0:6]  est;
    logic [0:11] ev;
    logic [0:11] es;
    eld = 7'b1000001;
    est = 7'b0001000;
    ev  = 12'b000110110110;
    es  = 12'b000000110000;
    do_reset();
    ld_vld = 1'b1; ld_base = 16'h2000; ld_len = 4'd2;
    st_vld = 1'b1; st_base = 16'h3000; st_len = 4'd2;
    issue_en = 1'b1;
    #1;
    checks++; if ({ld_rdy, st_rdy} !== {eld[0], est[0]}) begin errors++; $display("FAIL cont_rdy c=0 got %b exp %b%b", {ld_rdy, st_rdy}, eld[0], est[0]); end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 7) begin ld_vld = 1'b0; st_vld = 1'b0; end
      #1;
      if (k <= 6) begin
        checks++; if ({ld_rdy, st_rdy} !== {eld[k], est[k]}) begin errors++; $display("FAIL cont_rdy c=%0d got %b exp %b%b", k, {ld_rdy, st_rdy}, eld[k], est[k]); end
      end
      checks++; if ({addr_vld, addr_is_st} !== {ev[k-1], es[k-1]}) begin errors++; $display("FAIL cont_tag k=%0d got %b exp %b%b", k, {addr_vld, addr_is_st}, ev[k-1], es[k-1]); end
      if (k == 5) begin
        checks++; if ({agen_scalar, agen_cnt} !== {16'h3000, 4'd0}) begin errors++; $display("FAIL cont_st_beat got %h/%0d exp 3000/0", agen_scalar, agen_cnt); end
      end
      if (k == 8) begin
        checks++; if ({agen_scalar, agen_cnt} !== {16'h2000, 4'd0}) begin errors++; $display("FAIL cont_ld2_beat got %h/%0d exp 2000/0", agen_scalar, agen_cnt); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [0:9]    ie;
    logic [0:8]    ev;
    logic [0:8]    el;
    logic [CW-1:0] ec [5];
    ie = 10'b1101011111;
    ev = 9'b000101010;
    el = 9'b000000010;
    ec = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
    do_reset();
    ld_vld = 1'b1; ld_base = 16'h0500; ld_len = 4'd3; issue_en = ie[0];
    #1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) ld_vld = 1'b0;
      issue_en = ie[k];
      #1;
      checks++; if ({addr_vld, addr_last} !== {ev[k-1], el[k-1]}) begin errors++; $display("FAIL bp_tag k=%0d got %b exp %b%b", k, {addr_vld, addr_last}, ev[k-1], el[k-1]); end
      if (k >= 2 && k <= 6) begin
        checks++; if (agen_cnt !== ec[k-2]) begin errors++; $display("FAIL bp_cnt k=%0d got %0d exp %0d", k, agen_cnt, ec[k-2]); end
      end
    end
  endtask

  task automatic test_zero_length();
    logic [0:4] ed;
    ed = 5'b00100;
    do_reset();
    st_vld = 1'b1; st_base = 16'h0700; st_len = 4'd0; issue_en = 1'b1;
    #1;
    checks++; if ({ld_rdy, st_rdy} !== 2'b01) begin errors++; $display("FAIL zero_rdy got %b exp 01", {ld_rdy, st_rdy}); end
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) st_vld = 1'b0;
      #1;
      checks++; if ({addr_vld, done} !== {1'b0, ed[k-1]}) begin errors++; $display("FAIL zero_tag k=%0d got %b exp 0%b", k, {addr_vld, done}, ed[k-1]); end
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_on got %b exp 1", busy); end
        ld_vld = 1'b1; ld_len = 4'd1;
        #1;
        checks++; if (ld_rdy !== 1'b1) begin errors++; $display("FAIL zero_still_idle got %b exp 1", ld_rdy); end
        ld_vld = 1'b0;
        #1;
      end
      if (k == 4) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_off got %b exp 0", busy); end
      end
    end
  endtask

  task automatic test_max_length();
    int vcount;
    vcount = 0;
    do_reset();
    ld_vld = 1'b1; ld_base = 16'h0040; ld_len = 4'd15; issue_en = 1'b1;
    #1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 1) ld_vld = 1'b0;
      #1;
      if (addr_vld === 1'b1) vcount++;
      if (k == 16 || k == 17) begin
        checks++; if (agen_cnt !== 4'd14) begin errors++; $display("FAIL max_cnt k=%0d got %0d exp 14", k, agen_cnt); end
      end
      if (k == 16) begin
        ld_vld = 1'b1; ld_len = 4'd1;
        #1;
        checks++; if (ld_rdy !== 1'b1) begin errors++; $display("FAIL max_idle got %b exp 1", ld_rdy); end
        ld_vld = 1'b0;
        #1;
      end
      if (k == 17) begin
        checks++; if ({addr_vld, addr_last} !== 2'b10) begin errors++; $display("FAIL max_penult got %b exp 10", {addr_vld, addr_last}); end
      end
      if (k == 18) begin
        checks++; if ({addr_vld, addr_last, done} !== 3'b111) begin errors++; $display("FAIL max_last got %b exp 111", {addr_vld, addr_last, done}); end
      end
      if (k == 19) begin
        checks++; if ({addr_vld, busy} !== 2'b00) begin errors++; $display("FAIL max_end got %b exp 00", {addr_vld, busy}); end
      end
    end
    checks++; if (vcount != 15) begin errors++; $display("FAIL max_beats got %0d exp 15", vcount); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ld_vld = 1'b1; ld_base = 16'h0900; ld_len = 4'd5; issue_en = 1'b1;
    #1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) ld_vld = 1'b0;
      #1;
    end
    checks++; if (agen_cnt !== 4'd1) begin errors++; $display("FAIL midrst_pre_cnt got %0d exp 1", agen_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if ({agen_cnt, agen_scalar} !== {4'd0, 16'h0}) begin errors++; $display("FAIL midrst_agen got %0d/%h exp 0/0", agen_cnt, agen_scalar); end
    checks++; if ({addr_vld, addr_is_st, addr_last, done, busy} !== 5'b0) begin errors++; $display("FAIL midrst_flags got %b exp 00000", {addr_vld, addr_is_st, addr_last, done, busy}); end
    checks++; if ({ld_rdy, st_rdy} !== 2'b00) begin errors++; $display("FAIL midrst_rdy got %b exp 00", {ld_rdy, st_rdy}); end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if ({addr_vld, done} !== 2'b00) begin errors++; $display("FAIL midrst_ghost k=%0d got %b exp 00", k, {addr_vld, done}); end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_backpressure();
    test_zero_length();
    test_max_length();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
